// File: rtl/gtp_init_sequencer_pkg.sv
// rtl/gtp_init_sequencer_pkg.sv - shared constants and types for the GTP init sequencer
package gtp_init_sequencer_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_RESET_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT    = 4096;
    localparam int DEF_SUBRESET_CYCLES = 4;
    localparam int DEF_DONE_TIMEOUT    = 4096;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SUB_RESET  = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_READY      = 3'd4,
        ST_PWR_DOWN   = 3'd5
    } state_t;

    // Counter value seen in the last cycle of an N-cycle dwell (counter starts at 0).
    function automatic cnt_t last_count(input int cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/gtp_init_sync.sv
// rtl/gtp_init_sync.sv - width-parameterized two-flop synchronizer
module gtp_init_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; both clear while the sequencer is held in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gtp_init_sequencer.sv
// rtl/gtp_init_sequencer.sv - GTP reset/lock/powerdown bring-up sequencer
module gtp_init_sequencer
    import gtp_init_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES    = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int SUBRESET_CYCLES = DEF_SUBRESET_CYCLES,
    parameter int DONE_TIMEOUT    = DEF_DONE_TIMEOUT
) (
    input  logic       INIT_CLK,
    input  logic       RESET,
    input  logic       POWERDOWN,
    input  logic       PLLLKDET_IN,
    input  logic       RESETDONE_IN,
    input  logic       RXBUFERR_IN,
    input  logic       TXBUFERR_IN,
    output logic       GTPRESET_OUT,
    output logic       TXRESET_OUT,
    output logic       RXRESET_OUT,
    output logic       POWERDOWN_OUT,
    output logic       ENCOMMAALIGN_OUT,
    output logic       GT_READY_OUT,
    output logic [7:0] RETRY_COUNT_OUT,
    output logic [2:0] STATE_OUT
);

    localparam cnt_t RESET_LAST = last_count(RESET_CYCLES);
    localparam cnt_t LOCK_LAST  = last_count(LOCK_TIMEOUT);
    localparam cnt_t SUB_LAST   = last_count(SUBRESET_CYCLES);
    localparam cnt_t DONE_LAST  = last_count(DONE_TIMEOUT);

    logic [4:0] sync_d;
    logic [4:0] sync_q;
    logic       pd_s;
    logic       lock_s;
    logic       done_s;
    logic       rxerr_s;
    logic       txerr_s;

    state_t     state;
    state_t     state_next;
    cnt_t       cnt;
    logic [7:0] retry;
    logic       retry_inc;

    // POWERDOWN shares the synchronizer so every FSM input has the same 2-cycle latency.
    assign sync_d = {POWERDOWN, PLLLKDET_IN, RESETDONE_IN, RXBUFERR_IN, TXBUFERR_IN};

    gtp_init_sync #(
        .WIDTH(5)
    ) u_sync (
        .clk(INIT_CLK),
        .rst(RESET),
        .d  (sync_d),
        .q  (sync_q)
    );

    assign {pd_s, lock_s, done_s, rxerr_s, txerr_s} = sync_q;

    // State register, per-state dwell counter (cleared on any state change) and saturating retry count.
    always_ff @(posedge INIT_CLK) begin
        if (RESET) begin
            state <= ST_RESET_HOLD;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + cnt_t'(1);
            end
            if (retry_inc && (retry != 8'hFF)) begin
                retry <= retry + 8'd1;
            end
        end
    end

    // Next-state decode: powerdown overrides everything, then per-state progress/timeouts.
    always_comb begin
        state_next = state;
        retry_inc  = 1'b0;
        if (pd_s) begin
            state_next = ST_PWR_DOWN;
        end else begin
            case (state)
                ST_RESET_HOLD: begin
                    if (cnt == RESET_LAST) state_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = ST_SUB_RESET;
                    end else if (cnt == LOCK_LAST) begin
                        state_next = ST_RESET_HOLD;
                        retry_inc  = 1'b1;
                    end
                end
                ST_SUB_RESET: begin
                    if (cnt == SUB_LAST) state_next = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done_s) begin
                        state_next = ST_READY;
                    end else if (cnt == DONE_LAST) begin
                        state_next = ST_RESET_HOLD;
                        retry_inc  = 1'b1;
                    end
                end
                ST_READY: begin
                    // Lock loss needs a full reset, so it wins over a buffer error.
                    if (!lock_s) begin
                        state_next = ST_RESET_HOLD;
                    end else if (rxerr_s || txerr_s) begin
                        state_next = ST_SUB_RESET;
                    end
                end
                ST_PWR_DOWN: begin
                    state_next = ST_RESET_HOLD;
                end
                default: begin
                    state_next = ST_RESET_HOLD;
                end
            endcase
        end
    end

    // Output decode purely from the registered state.
    always_comb begin
        GTPRESET_OUT     = 1'b0;
        TXRESET_OUT      = 1'b0;
        RXRESET_OUT      = 1'b0;
        POWERDOWN_OUT    = 1'b0;
        ENCOMMAALIGN_OUT = 1'b0;
        GT_READY_OUT     = 1'b0;
        case (state)
            ST_RESET_HOLD: begin
                GTPRESET_OUT = 1'b1;
                TXRESET_OUT  = 1'b1;
                RXRESET_OUT  = 1'b1;
            end
            ST_WAIT_LOCK, ST_SUB_RESET: begin
                TXRESET_OUT = 1'b1;
                RXRESET_OUT = 1'b1;
            end
            ST_READY: begin
                ENCOMMAALIGN_OUT = 1'b1;
                GT_READY_OUT     = 1'b1;
            end
            ST_PWR_DOWN: begin
                GTPRESET_OUT  = 1'b1;
                TXRESET_OUT   = 1'b1;
                RXRESET_OUT   = 1'b1;
                POWERDOWN_OUT = 1'b1;
            end
            default: begin
                GTPRESET_OUT = 1'b0;
            end
        endcase
    end

    assign STATE_OUT       = state;
    assign RETRY_COUNT_OUT = retry;

endmodule

// File: tb/tb_gtp_init_sequencer.sv
// tb/tb_gtp_init_sequencer.sv - scoreboard bench for the GTP init sequencer
module tb_gtp_init_sequencer;

    localparam int RST_CYC = 16;
    localparam int SUB_CYC = 4;
    localparam int LOCK_TO = 100;
    localparam int DONE_TO = 60;

    localparam logic [2:0] S_RH = 3'd0;
    localparam logic [2:0] S_WL = 3'd1;
    localparam logic [2:0] S_SR = 3'd2;
    localparam logic [2:0] S_WD = 3'd3;
    localparam logic [2:0] S_RD = 3'd4;
    localparam logic [2:0] S_PD = 3'd5;

    logic       INIT_CLK;
    logic       RESET;
    logic       POWERDOWN;
    logic       PLLLKDET_IN;
    logic       RESETDONE_IN;
    logic       RXBUFERR_IN;
    logic       TXBUFERR_IN;
    logic       GTPRESET_OUT;
    logic       TXRESET_OUT;
    logic       RXRESET_OUT;
    logic       POWERDOWN_OUT;
    logic       ENCOMMAALIGN_OUT;
    logic       GT_READY_OUT;
    logic [7:0] RETRY_COUNT_OUT;
    logic [2:0] STATE_OUT;

    gtp_init_sequencer #(
        .RESET_CYCLES   (RST_CYC),
        .LOCK_TIMEOUT   (LOCK_TO),
        .SUBRESET_CYCLES(SUB_CYC),
        .DONE_TIMEOUT   (DONE_TO)
    ) dut (
        .INIT_CLK        (INIT_CLK),
        .RESET           (RESET),
        .POWERDOWN       (POWERDOWN),
        .PLLLKDET_IN     (PLLLKDET_IN),
        .RESETDONE_IN    (RESETDONE_IN),
        .RXBUFERR_IN     (RXBUFERR_IN),
        .TXBUFERR_IN     (TXBUFERR_IN),
        .GTPRESET_OUT    (GTPRESET_OUT),
        .TXRESET_OUT     (TXRESET_OUT),
        .RXRESET_OUT     (RXRESET_OUT),
        .POWERDOWN_OUT   (POWERDOWN_OUT),
        .ENCOMMAALIGN_OUT(ENCOMMAALIGN_OUT),
        .GT_READY_OUT    (GT_READY_OUT),
        .RETRY_COUNT_OUT (RETRY_COUNT_OUT),
        .STATE_OUT       (STATE_OUT)
    );

    initial begin
        INIT_CLK = 1'b0;
        forever #5 INIT_CLK = ~INIT_CLK;
    end

    typedef struct {
        logic [2:0] st;
        int         dur;
        int         retry;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    logic [5:0] outs_act;
    assign outs_act = {GTPRESET_OUT, TXRESET_OUT, RXRESET_OUT,
                       POWERDOWN_OUT, ENCOMMAALIGN_OUT, GT_READY_OUT};

    // {gtpreset, txreset, rxreset, powerdown, encommaalign, gt_ready} per state
    function automatic logic [5:0] outs_for(input logic [2:0] st);
        case (st)
            S_RH:    return 6'b111000;
            S_WL:    return 6'b011000;
            S_SR:    return 6'b011000;
            S_WD:    return 6'b000000;
            S_RD:    return 6'b000011;
            S_PD:    return 6'b111100;
            default: return 6'b000000;
        endcase
    endfunction

    // dur = cycles spent in the state being left (0 = not checked)
    task automatic expect_tr(input logic [2:0] st, input int dur, input int retry);
        exp_t e;
        e.st    = st;
        e.dur   = dur;
        e.retry = retry;
        sb.push_back(e);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Transition monitor: on every state change pop the next expectation and compare.
    initial begin : monitor
        logic [2:0] prev_st;
        int         dwell;
        exp_t       e;
        logic       ok;
        prev_st = S_RH;
        dwell   = 0;
        forever begin
            @(negedge INIT_CLK);
            if (RESET) begin
                prev_st = STATE_OUT;
                dwell   = 0;
            end else if (STATE_OUT != prev_st) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_transition: state %0d -> %0d after %0d cycles, none expected",
                             prev_st, STATE_OUT, dwell);
                end else begin
                    e  = sb.pop_front();
                    ok = (STATE_OUT == e.st) && ((e.dur == 0) || (dwell == e.dur)) &&
                         (outs_act == outs_for(e.st)) && (int'(RETRY_COUNT_OUT) == e.retry);
                    if (!ok) begin
                        errors++;
                        $display("FAIL transition %0d->: state %0d/%0d dwell %0d/%0d outs %b/%b retry %0d/%0d (got/expected)",
                                 prev_st, STATE_OUT, e.st, dwell, e.dur, outs_act, outs_for(e.st),
                                 RETRY_COUNT_OUT, e.retry);
                    end
                end
                prev_st = STATE_OUT;
                dwell   = 1;
            end else begin
                dwell++;
            end
        end
    end

    task automatic step(input int m);
        repeat (m) @(posedge INIT_CLK);
        #1;
    endtask

    // Returns at the first negedge on which the target state is visible.
    task automatic wait_state(input logic [2:0] st);
        int n;
        n = 0;
        @(negedge INIT_CLK);
        while ((STATE_OUT != st) && (n < 5000)) begin
            @(negedge INIT_CLK);
            n++;
        end
        check_val("reach_state", int'(STATE_OUT), int'(st));
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < limit)) begin
            @(negedge INIT_CLK);
            n++;
        end
        check_val("pending_transitions", sb.size(), 0);
    endtask

    initial begin : stimulus
        RESET        = 1'b1;
        POWERDOWN    = 1'b0;
        PLLLKDET_IN  = 1'b0;
        RESETDONE_IN = 1'b0;
        RXBUFERR_IN  = 1'b0;
        TXBUFERR_IN  = 1'b0;
        step(3);
        @(negedge INIT_CLK);
        check_val("reset_state", int'(STATE_OUT), 0);
        check_val("reset_outs", int'(outs_act), int'(6'b111000));
        check_val("reset_retry", int'(RETRY_COUNT_OUT), 0);

        // Nominal bring-up: lock 30 cycles after release, done 10 cycles after TXRESET falls
        expect_tr(S_WL, 16, 0);
        expect_tr(S_SR, 17, 0);
        expect_tr(S_WD, 4, 0);
        expect_tr(S_RD, 13, 0);
        step(1);
        RESET = 1'b0;
        wait_state(S_WL);
        step(14);
        PLLLKDET_IN = 1'b1;
        wait_state(S_WD);
        step(10);
        RESETDONE_IN = 1'b1;

        // RX buffer error in READY: sub-reset only
        expect_tr(S_SR, 5, 0);
        expect_tr(S_WD, 4, 0);
        expect_tr(S_RD, 8, 0);
        wait_state(S_RD);
        step(2);
        RXBUFERR_IN  = 1'b1;
        RESETDONE_IN = 1'b0;
        step(3);
        RXBUFERR_IN = 1'b0;
        wait_state(S_WD);
        step(5);
        RESETDONE_IN = 1'b1;

        // Lock loss together with TX buffer error: full reset wins, no retry count
        expect_tr(S_RH, 5, 0);
        expect_tr(S_WL, 16, 0);
        expect_tr(S_SR, 4, 0);
        expect_tr(S_WD, 4, 0);
        wait_state(S_RD);
        step(2);
        PLLLKDET_IN  = 1'b0;
        TXBUFERR_IN  = 1'b1;
        RESETDONE_IN = 1'b0;
        step(3);
        TXBUFERR_IN = 1'b0;
        wait_state(S_WL);
        step(1);
        PLLLKDET_IN = 1'b1;

        // Powerdown during WAIT_DONE, then fresh sequence on release
        expect_tr(S_PD, 6, 0);
        expect_tr(S_RH, 8, 0);
        expect_tr(S_WL, 16, 0);
        expect_tr(S_SR, 1, 0);
        expect_tr(S_WD, 4, 0);
        expect_tr(S_RD, 5, 0);
        wait_state(S_WD);
        step(3);
        POWERDOWN = 1'b1;
        wait_state(S_PD);
        step(5);
        POWERDOWN = 1'b0;
        wait_state(S_WD);
        step(2);
        RESETDONE_IN = 1'b1;

        // Lock lost for good: 260 lock timeouts, retry count saturates at 255
        expect_tr(S_RH, 5, 0);
        expect_tr(S_WL, 16, 0);
        for (int n = 1; n <= 260; n++) begin
            expect_tr(S_RH, LOCK_TO, (n > 255) ? 255 : n);
            expect_tr(S_WL, 16, (n > 255) ? 255 : n);
        end
        wait_state(S_RD);
        step(2);
        PLLLKDET_IN  = 1'b0;
        RESETDONE_IN = 1'b0;
        wait_drain(32000);
        expect_tr(S_SR, 0, 255);
        step(1);
        PLLLKDET_IN = 1'b1;

        // RESET in SUB_RESET: back to reset values, retry cleared, full restart
        wait_state(S_SR);
        step(1);
        RESET = 1'b1;
        step(1);
        @(negedge INIT_CLK);
        check_val("midreset_state", int'(STATE_OUT), 0);
        check_val("midreset_outs", int'(outs_act), int'(6'b111000));
        check_val("midreset_retry", int'(RETRY_COUNT_OUT), 0);
        expect_tr(S_WL, 16, 0);
        expect_tr(S_SR, 1, 0);
        expect_tr(S_WD, 4, 0);
        expect_tr(S_RH, DONE_TO, 1);
        expect_tr(S_WL, 16, 1);
        step(1);
        RESET = 1'b0;
        wait_state(S_WD);
        step(1);
        PLLLKDET_IN = 1'b0;
        wait_drain(500);
        repeat (5) @(negedge INIT_CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gtp_init_sequencer.md
GTP_INIT_SEQUENCER -- requirements
Module: gtp_init_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16, cycles GTPRESET_OUT is held high per attempt (range 1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, cycles allowed in WAIT_LOCK before a retry.
REQ-003 SHALL have parameter SUBRESET_CYCLES, default 4, cycles TXRESET_OUT/RXRESET_OUT are held high.
REQ-004 SHALL have parameter DONE_TIMEOUT, default 4096, cycles allowed in WAIT_DONE before a retry.
REQ-005 SHALL have ports:
 INIT_CLK  in  1  sole clock; all logic rising-edge.
 RESET  in  1  synchronous, active-high reset.
 POWERDOWN  in  1  request to power down the GTP.
 PLLLKDET_IN  in  1  PLL lock from the GTP wrapper; asynchronous.
 RESETDONE_IN  in  1  GTP reset done; asynchronous.
 RXBUFERR_IN  in  1  RX elastic buffer error; asynchronous.
 TXBUFERR_IN  in  1  TX buffer error; asynchronous.
 GTPRESET_OUT  out  1  drives the wrapper GTPRESET_IN.
 TXRESET_OUT  out  1  drives TXRESET_IN.
 RXRESET_OUT  out  1  drives RXRESET_IN.
 POWERDOWN_OUT  out  1  drives the wrapper POWERDOWN_IN.
 ENCOMMAALIGN_OUT  out  1  drives ENMCOMMAALIGN_IN and ENPCOMMAALIGN_IN.
 GT_READY_OUT  out  1  link may be used.
 RETRY_COUNT_OUT  out  8  saturating count of full-reset retries.
 STATE_OUT  out  3  current state encoding.

Function
REQ-006 SHALL pass each of the four asynchronous inputs through a 2-flop synchronizer, giving 2 cycles of latency before the state machine sees the input.
REQ-007 SHALL implement the states RESET_HOLD=0, WAIT_LOCK=1, SUB_RESET=2, WAIT_DONE=3, READY=4 and PWR_DOWN=5.
REQ-008 SHALL drive every output from registered state; no output may be combinational from inputs.
REQ-009 In RESET_HOLD, GTPRESET_OUT, TXRESET_OUT and RXRESET_OUT SHALL be 1; the block SHALL go to WAIT_LOCK after exactly RESET_CYCLES cycles in RESET_HOLD.
REQ-010 In WAIT_LOCK, GTPRESET_OUT SHALL be 0 and TXRESET_OUT/RXRESET_OUT SHALL stay 1; synchronized lock SHALL move the block to SUB_RESET.
REQ-011 In WAIT_LOCK, if lock is not seen within LOCK_TIMEOUT cycles, the block SHALL go to RESET_HOLD and increment RETRY_COUNT_OUT.
REQ-012 SUB_RESET SHALL hold TXRESET_OUT/RXRESET_OUT at 1 for exactly SUBRESET_CYCLES cycles, then go to WAIT_DONE.
REQ-013 In WAIT_DONE, synchronized RESETDONE SHALL move the block to READY; after DONE_TIMEOUT cycles without it, the block SHALL go to RESET_HOLD and increment RETRY_COUNT_OUT.
REQ-014 In READY, GT_READY_OUT and ENCOMMAALIGN_OUT SHALL be 1 and all reset outputs SHALL be 0.
REQ-015 From READY, loss of synchronized lock SHALL go to RESET_HOLD; RETRY_COUNT_OUT SHALL NOT increment.
REQ-016 From READY, a synchronized RXBUFERR or TXBUFERR with lock still present SHALL go to SUB_RESET.
REQ-017 If lock loss and a buffer error occur in the same cycle, lock loss SHALL take priority.
REQ-018 A synchronized POWERDOWN in any state SHALL go to PWR_DOWN (highest priority). PWR_DOWN SHALL drive POWERDOWN_OUT=1, all reset outputs=1 and GT_READY_OUT=0.
REQ-019 On POWERDOWN deassertion, the block SHALL leave PWR_DOWN for RESET_HOLD with a fresh RESET_CYCLES count.
REQ-020 The single 16-bit cycle counter SHALL clear on every state change.
REQ-021 RETRY_COUNT_OUT SHALL saturate at 255 and clear only on RESET.
REQ-022 GT_READY_OUT SHALL drop in the same cycle STATE_OUT leaves READY.

Reset
REQ-023 While RESET=1, the block SHALL be in RESET_HOLD with the counter at 0, RETRY_COUNT_OUT=0, synchronizers at 0, GTPRESET_OUT/TXRESET_OUT/RXRESET_OUT=1 and every other output 0.
REQ-024 Asserting RESET mid-sequence SHALL restart from RESET_HOLD on the next edge, discarding all progress.
REQ-025 The RESET_CYCLES count SHALL start in the first cycle with RESET=0.

Structure
REQ-026 A shared package SHALL hold the state encoding constants, the parameter defaults and the counter width (16).
REQ-027 One sub-module, gtp_init_sync (2-flop synchronizer, width-parameterized), SHALL be instantiated for the four inputs.

Verification
REQ-028 Nominal: release RESET; lock at cycle 30; RESETDONE 10 cycles after TXRESET_OUT falls -> GTPRESET_OUT high for exactly 16 cycles; GT_READY_OUT=1; RETRY_COUNT_OUT=0.
REQ-029 Lock timeout: PLLLKDET_IN held 0 -> after 4096 WAIT_LOCK cycles, GTPRESET_OUT re-pulses; RETRY_COUNT_OUT increments once per attempt and sticks at 255 after 260 attempts.
REQ-030 Buffer error in READY: RXBUFERR_IN pulses for 3 cycles -> TXRESET_OUT/RXRESET_OUT high for 4 cycles, GTPRESET_OUT stays 0, READY regained after RESETDONE.
REQ-031 Simultaneous: lock loss and TXBUFERR_IN in the same cycle -> STATE_OUT=0, not 2.
REQ-032 Powerdown: POWERDOWN=1 during WAIT_DONE -> STATE_OUT=5, POWERDOWN_OUT=1; on release, a 16-cycle GTPRESET_OUT pulse then the normal sequence.
REQ-033 Reset mid-operation: RESET pulsed in SUB_RESET -> all outputs at reset values, counter restarts, RETRY_COUNT_OUT=0.
